// File: rtl/debug_unit.sv
// Host-side debug/program loader for the pipelined MIPS core: UART command decode,
// program memory load, run/step gating and PC + register file dump. Optional: DEBUG_UNIT_STEP_EN.
module debug_unit #(
  parameter int LEN          = 32,
  parameter int NB_PROG_ADDR = 4,
  parameter int NB_BYTE      = 8,
  parameter int NB_REG_ADDR  = 5
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [NB_BYTE-1:0]      i_rx_data,
  input  logic                    i_rx_valid,
  output logic [NB_BYTE-1:0]      o_tx_data,
  output logic                    o_tx_valid,
  input  logic                    i_tx_ready,
  output logic                    o_prog_we,
  output logic [NB_PROG_ADDR-1:0] o_prog_addr,
  output logic [LEN-1:0]          o_prog_data,
  output logic                    o_cpu_en,
  input  logic                    i_cpu_halt,
  input  logic [LEN-1:0]          i_pc,
  output logic [NB_REG_ADDR-1:0]  o_reg_addr,
  input  logic [LEN-1:0]          i_reg_data
);

  localparam int BPW        = LEN / NB_BYTE;
  localparam int BC_W       = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int DUMP_BYTES = BPW * (1 + 2**NB_REG_ADDR);
  localparam int IDX_W      = $clog2(DUMP_BYTES);
  localparam int CNT_W      = ((NB_BYTE > NB_PROG_ADDR) ? NB_BYTE : NB_PROG_ADDR) + 1;

  localparam logic [NB_BYTE-1:0] CMD_LOAD = NB_BYTE'(8'h4C);
  localparam logic [NB_BYTE-1:0] CMD_RUN  = NB_BYTE'(8'h52);
`ifdef DEBUG_UNIT_STEP_EN
  localparam logic [NB_BYTE-1:0] CMD_STEP = NB_BYTE'(8'h53);
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_CNT,
    ST_LOAD_DATA,
    ST_WRITE,
    ST_RUN,
`ifdef DEBUG_UNIT_STEP_EN
    ST_STEP,
`endif
    ST_DUMP
  } state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  words_left;
  logic [NB_PROG_ADDR-1:0] word_idx;
  logic [BC_W-1:0]   byte_cnt;
  logic [LEN-1:0]    word_q;
  logic [LEN-1:0]    pc_cap;
  logic [IDX_W-1:0]  tx_idx;
  logic              tx_valid_q;

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: begin
        if (i_rx_valid) begin
          if (i_rx_data == CMD_LOAD)
            state_n = ST_LOAD_CNT;
          else if (i_rx_data == CMD_RUN)
            state_n = i_cpu_halt ? ST_DUMP : ST_RUN;
`ifdef DEBUG_UNIT_STEP_EN
          else if (i_rx_data == CMD_STEP)
            state_n = ST_STEP;
`endif
        end
      end
      ST_LOAD_CNT:  if (i_rx_valid) state_n = ST_LOAD_DATA;
      ST_LOAD_DATA: if (i_rx_valid && byte_cnt == BC_W'(BPW - 1)) state_n = ST_WRITE;
      ST_WRITE:     state_n = (words_left == CNT_W'(1)) ? ST_IDLE : ST_LOAD_DATA;
      ST_RUN:       if (i_cpu_halt) state_n = ST_DUMP;
`ifdef DEBUG_UNIT_STEP_EN
      ST_STEP:      state_n = ST_DUMP;
`endif
      ST_DUMP: begin
        if (tx_valid_q && i_tx_ready && tx_idx == IDX_W'(DUMP_BYTES - 1))
          state_n = ST_IDLE;
      end
      default:      state_n = ST_IDLE;
    endcase
  end

  // The PC is captured in the first DUMP cycle (tx_valid still low): the CPU is
  // already frozen there, so the value includes the last enabled cycle's update.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state      <= ST_IDLE;
      words_left <= '0;
      word_idx   <= '0;
      byte_cnt   <= '0;
      word_q     <= '0;
      pc_cap     <= '0;
      tx_idx     <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        ST_LOAD_CNT: begin
          if (i_rx_valid) begin
            words_left <= (i_rx_data == '0) ? CNT_W'(2**NB_PROG_ADDR) : CNT_W'(i_rx_data);
            word_idx   <= '0;
            byte_cnt   <= '0;
          end
        end
        ST_LOAD_DATA: begin
          if (i_rx_valid) begin
            word_q   <= {word_q[LEN-NB_BYTE-1:0], i_rx_data};
            byte_cnt <= (byte_cnt == BC_W'(BPW - 1)) ? '0 : byte_cnt + BC_W'(1);
          end
        end
        ST_WRITE: begin
          word_idx   <= word_idx + NB_PROG_ADDR'(1);
          words_left <= words_left - CNT_W'(1);
        end
        ST_DUMP: begin
          if (!tx_valid_q) begin
            pc_cap     <= i_pc;
            tx_valid_q <= 1'b1;
          end else if (i_tx_ready) begin
            if (tx_idx == IDX_W'(DUMP_BYTES - 1)) begin
              tx_idx     <= '0;
              tx_valid_q <= 1'b0;
            end else begin
              tx_idx <= tx_idx + IDX_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_prog_we   = (state == ST_WRITE);
  assign o_prog_addr = word_idx;
  assign o_prog_data = word_q;
`ifdef DEBUG_UNIT_STEP_EN
  assign o_cpu_en    = (state == ST_RUN) || (state == ST_STEP);
`else
  assign o_cpu_en    = (state == ST_RUN);
`endif
  assign o_tx_valid  = tx_valid_q;
  assign o_reg_addr  = (tx_valid_q && tx_idx >= IDX_W'(BPW))
                       ? NB_REG_ADDR'((tx_idx - IDX_W'(BPW)) >> BC_W) : '0;

  logic [LEN-1:0]  tx_word;
  logic [BC_W-1:0] tx_sel;

  always_comb begin
    tx_word   = (tx_idx < IDX_W'(BPW)) ? pc_cap : i_reg_data;
    tx_sel    = tx_idx[BC_W-1:0];
    o_tx_data = '0;
    if (tx_valid_q)
      o_tx_data = tx_word[LEN-1-int'(tx_sel)*NB_BYTE -: NB_BYTE];
  end

endmodule

// File: doc/debug_unit.md
# debug_unit

Host-side debug and program loader for the pipelined MIPS core, sitting between the UART byte interface and `top_mips`. It receives command bytes from the UART receiver and can do three things: write 32-bit instructions into program memory, gate CPU execution (run-to-halt or single step), and stream the PC and the full register file back through the UART transmitter.

## Interface
Parameters:
- LEN, 32, datapath/instruction width
- NB_PROG_ADDR, 4, program memory address width (depth 2^NB_PROG_ADDR words)
- NB_BYTE, 8, UART byte width
- NB_REG_ADDR, 5, register file address width

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  asynchronous, active-low reset
- i_rx_data  in  NB_BYTE  received byte
- i_rx_valid  in  1  one-cycle strobe, i_rx_data valid
- o_tx_data  out  NB_BYTE  byte to transmit
- o_tx_valid  out  1  o_tx_data valid
- i_tx_ready  in  1  transmitter can accept a byte
- o_prog_we  out  1  program memory write enable
- o_prog_addr  out  NB_PROG_ADDR  program memory word address
- o_prog_data  out  LEN  program memory write word
- o_cpu_en  out  1  CPU clock enable (pipeline advances when high)
- i_cpu_halt  in  1  CPU has retired HALT, level
- i_pc  in  LEN  current PC
- o_reg_addr  out  NB_REG_ADDR  register file read address
- i_reg_data  in  LEN  register file data, combinational read of o_reg_addr

## Operation
- Commands are accepted only in IDLE. Any other byte in IDLE is ignored. All RX bytes outside IDLE, LOAD_CNT and LOAD_DATA are dropped.
- 'L' (0x4C) moves to LOAD_CNT. The next byte is N, the word count; N=0 means 2^NB_PROG_ADDR. Then LOAD_DATA takes 4N bytes, MSB first per word.
- After each 4th byte, a WRITE cycle follows: o_prog_we=1 for one cycle, o_prog_addr = word index (starting at 0, wrapping modulo depth), o_prog_data = the assembled word. After the Nth write, the unit returns to IDLE.
- 'R' (0x52) moves to RUN. o_cpu_en=1 until i_cpu_halt is sampled high, then o_cpu_en=0 and the unit moves to DUMP.
- 'S' (0x53) moves to STEP: o_cpu_en=1 for exactly one cycle, then DUMP.
- DUMP sends 132 bytes through the valid/ready handshake:
  - bytes 0-3: PC, MSB first, captured on DUMP entry;
  - bytes 4-131: registers 0..31, 4 bytes each, MSB first, with o_reg_addr = (k-4)>>2.
  - After the byte 131 handshake, the unit returns to IDLE.
- States: IDLE, LOAD_CNT, LOAD_DATA, WRITE, RUN, STEP, DUMP.

## Timing
- Reset values: all outputs 0, state IDLE, word index 0, byte counters 0.
- Reset asserted mid-operation aborts immediately. A partial word is discarded, and no further write or TX occurs.
- o_prog_we rises in the cycle after the i_rx_valid of a word's 4th byte.
- o_cpu_en rises in the cycle after the i_rx_valid of 'R' or 'S'. It falls in the cycle after i_cpu_halt is sampled high.
- If i_cpu_halt is already high when 'R' is received, o_cpu_en never rises and DUMP is entered directly.
- TX transfer occurs on a cycle with o_tx_valid && i_tx_ready. o_tx_valid rises the cycle after DUMP entry. o_tx_data is held stable while o_tx_valid=1 and !i_tx_ready. The next byte is presented in the cycle after a transfer.
- Register bytes are re-read each cycle via the combinational path. This is valid because the CPU is frozen (o_cpu_en=0) throughout DUMP.

## Configuration
- DEBUG_UNIT_STEP_EN:
  - Defined: 'S' is implemented as above.
  - Undefined: the STEP state is not built, and 0x53 is treated as an unknown byte (ignored in IDLE).

## Test plan
- Load: 'L', 0x02, 20 01 00 05, 00 00 00 0C -> two write pulses: addr 0 data 0x20010005, then addr 1 data 0x0000000C; unit back in IDLE.
- Count 0 with NB_PROG_ADDR=4: 'L', 0x00, 64 bytes -> 16 writes, addr 0..15.
- Run: 'R' with i_cpu_halt rising after 10 cycles -> o_cpu_en high for exactly 10 cycles, then 132 bytes with PC=0x00000028 first and r1=0x00000005 at bytes 8-11.
- Backpressure: i_tx_ready toggles every 3 cycles during DUMP -> o_tx_data stable while stalled, no byte lost or duplicated, 132 transfers.
- Step (macro on): 'S' -> o_cpu_en high one cycle then dump. Macro off: 'S' -> no o_cpu_en, no TX.
- Reset mid-load: i_rst low after 2 data bytes, then a fresh 'L' 0x01 + 4 bytes -> only one write, at addr 0.
